// File: rtl/rcv_pkt.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rcv_pkt -- framed packet receiver with a commit/rollback payload FIFO.
//
// Frame on the byte stream (only strobed bytes count):
//   0x7E, LEN, LEN payload bytes [, CHK]
// CHK is the modulo-256 sum of LEN and all payload bytes. It is present only
// when the macro RCV_PKT_CHKSUM_EN is defined. In the default build the frame
// ends with its last payload byte and is committed on that byte.
//
// Payload bytes go into the FIFO at a tentative write pointer. They reach the
// outputs only once the frame is committed, which copies the tentative pointer
// into the committed pointer. A dropped frame rewinds the tentative pointer to
// the committed pointer.
//
// Ports:
//   rcv_pkt_clk   in   clock, all state changes on the rising edge
//   rcv_pkt_rst   in   synchronous active-high reset
//   rcv_pkt_in1   in   [7:0] received byte
//   rcv_pkt_in2   in   byte strobe, rcv_pkt_in1 is valid this cycle
//   rcv_pkt_in3   in   line error, aborts a frame in progress
//   rcv_pkt_in4   in   downstream ready
//   rcv_pkt_out1  out  [7:0] payload byte at the FIFO head (0 when empty)
//   rcv_pkt_out2  out  payload valid, committed FIFO not empty
//   rcv_pkt_out3  out  head byte is the last byte of its packet
//   rcv_pkt_out4  out  one-cycle pulse when a frame is dropped
//
// Output handshake: a byte is transferred on every rising edge where
// rcv_pkt_out2 and rcv_pkt_in4 are both high. While rcv_pkt_out2 is high and
// rcv_pkt_in4 is low, rcv_pkt_out1/rcv_pkt_out3 hold their value.
// -----------------------------------------------------------------------------
module rcv_pkt #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned MAX_LEN = 15
) (
   input  logic       rcv_pkt_clk,
   input  logic       rcv_pkt_rst,
   input  logic [7:0] rcv_pkt_in1,
   input  logic       rcv_pkt_in2,
   input  logic       rcv_pkt_in3,
   input  logic       rcv_pkt_in4,
   output logic [7:0] rcv_pkt_out1,
   output logic       rcv_pkt_out2,
   output logic       rcv_pkt_out3,
   output logic       rcv_pkt_out4
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [7:0]  SOF     = 8'h7E;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

`ifdef RCV_PKT_CHKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, LEN = 2'd1, DATA = 2'd2, CHK = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, LEN = 2'd1, DATA = 2'd2} state_t;
`endif

   state_t      r_state;
   logic [7:0]  r_cnt;        // payload bytes still expected
   logic [AW:0] r_wr_ptr;     // tentative write pointer
   logic [AW:0] r_cmt_ptr;    // committed write pointer
   logic [AW:0] r_rd_ptr;     // read pointer
   logic        r_drop;
   logic [8:0]  r_mem [DEPTH]; // {last, byte}
`ifdef RCV_PKT_CHKSUM_EN
   logic [7:0]  r_sum;
`endif

   logic        w_empty;
   logic        w_pop;
   logic [AW:0] w_used;
   logic [AW:0] w_free;
   logic        w_len_ok;
   logic        w_wr_en;
   logic        w_abort;
   logic [8:0]  w_head;

   assign w_empty = (r_cmt_ptr == r_rd_ptr);
   assign w_pop   = !w_empty && rcv_pkt_in4;

   // Used space counts committed entries plus pending (tentative) writes.
   // The extra pointer bit keeps a full FIFO distinct from an empty one.
   assign w_used   = r_wr_ptr - r_rd_ptr;
   assign w_free   = DEPTH_W - w_used;
   assign w_len_ok = (rcv_pkt_in1 != 8'd0) &&
                     (32'(rcv_pkt_in1) <= MAX_LEN) &&
                     (32'(rcv_pkt_in1) <= 32'(w_free));

   // A line error outside IDLE aborts the frame and wins over the byte.
   assign w_abort = (r_state != IDLE) && rcv_pkt_in3;
   assign w_wr_en = (r_state == DATA) && rcv_pkt_in2 && !rcv_pkt_in3;

   assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
   assign rcv_pkt_out2 = !w_empty;
   assign rcv_pkt_out1 = w_empty ? 8'h00 : w_head[7:0];
   assign rcv_pkt_out3 = !w_empty && w_head[8];
   assign rcv_pkt_out4 = r_drop;

   // Payload storage, no reset needed: entries are only visible once committed.
   always_ff @(posedge rcv_pkt_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {(r_cnt == 8'd1), rcv_pkt_in1};
      end
   end

   always_ff @(posedge rcv_pkt_clk) begin
      if (rcv_pkt_rst) begin
         r_state   <= IDLE;
         r_cnt     <= 8'd0;
         r_wr_ptr  <= '0;
         r_cmt_ptr <= '0;
         r_rd_ptr  <= '0;
         r_drop    <= 1'b0;
`ifdef RCV_PKT_CHKSUM_EN
         r_sum     <= 8'd0;
`endif
      end else begin
         r_drop <= 1'b0;

         // The read side is independent of the parser, so a pop can share
         // a cycle with a tentative write or a commit.
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end

         if (w_abort) begin
            r_wr_ptr <= r_cmt_ptr;
            r_drop   <= 1'b1;
            r_state  <= IDLE;
         end else if (rcv_pkt_in2) begin
            case (r_state)
               IDLE: begin
                  if (rcv_pkt_in1 == SOF) begin
                     r_state <= LEN;
                  end
               end
               LEN: begin
                  if (w_len_ok) begin
                     r_cnt   <= rcv_pkt_in1;
`ifdef RCV_PKT_CHKSUM_EN
                     r_sum   <= rcv_pkt_in1;
`endif
                     r_state <= DATA;
                  end else begin
                     r_drop  <= 1'b1;
                     r_state <= IDLE;
                  end
               end
               DATA: begin
                  r_wr_ptr <= r_wr_ptr + PTR_ONE;
                  r_cnt    <= r_cnt - 8'd1;
`ifdef RCV_PKT_CHKSUM_EN
                  r_sum    <= r_sum + rcv_pkt_in1;
                  if (r_cnt == 8'd1) begin
                     r_state <= CHK;
                  end
`else
                  if (r_cnt == 8'd1) begin
                     r_cmt_ptr <= r_wr_ptr + PTR_ONE;
                     r_state   <= IDLE;
                  end
`endif
               end
`ifdef RCV_PKT_CHKSUM_EN
               CHK: begin
                  if (rcv_pkt_in1 == r_sum) begin
                     r_cmt_ptr <= r_wr_ptr;
                  end else begin
                     r_wr_ptr <= r_cmt_ptr;
                     r_drop   <= 1'b1;
                  end
                  r_state <= IDLE;
               end
`endif
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule
